// File: rtl/serial_mag_compare.sv
// ============================================================================
// Module   : serial_mag_compare
// Brief    : Bit-serial magnitude comparator. It takes MSB-first per-bit compare
//            flags and returns a word verdict (A==B, A>B, A<B) over valid/ready.
//            The optional flag-consistency checker is enabled by SMC_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_mag_compare #(
    parameter int  WIDTH = 8,
    localparam int CNT_W = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_eq,
    input  logic             bit_ne,
    input  logic             bit_gt,
    input  logic             bit_lt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             res_eq,
    output logic             res_gt,
    output logic             res_lt,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             flag_err
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_decided;
    logic             r_dir_gt;
    logic             w_accept;
    logic             w_last;
    logic             w_decided_eff;

    assign w_accept = in_valid & (r_state != S_DONE);
    assign w_last   = (r_beat_cnt == C_LAST);
    // The first beat of a word starts from a clean slate. A verdict from an
    // earlier word must not carry over.
    assign w_decided_eff = r_decided & (r_state != S_IDLE);
    assign beat_cnt = r_beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        res_eq      = 1'b0;
        res_gt      = 1'b0;
        res_lt      = 1'b0;
        case (r_state)
            S_IDLE, S_SCAN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_last ? S_DONE : S_SCAN;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                res_gt    = r_decided & r_dir_gt;
                res_lt    = r_decided & ~r_dir_gt;
                res_eq    = ~r_decided;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The first differing bit pair (the MSB) locks the direction. If gt and
    // lt are both high on the same beat, GT wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_decided  <= 1'b0;
            r_dir_gt   <= 1'b0;
        end else if (w_accept) begin
            r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
            if (!w_decided_eff && (bit_gt || bit_lt)) begin
                r_decided <= 1'b1;
                r_dir_gt  <= bit_gt;
            end else begin
                r_decided <= w_decided_eff;
            end
        end
    end

`ifdef SMC_CHECK_EN
    logic r_flag_err;
    logic w_flag_bad;

    assign w_flag_bad = (({1'b0, bit_eq} + {1'b0, bit_gt} + {1'b0, bit_lt}) != 2'd1)
                      | (bit_ne != ~bit_eq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_err <= 1'b0;
        end else if (w_accept && w_flag_bad) begin
            r_flag_err <= 1'b1;
        end
    end

    assign flag_err = r_flag_err;
`else
    logic w_unused_flags;
    assign w_unused_flags = bit_eq ^ bit_ne;
    assign flag_err = 1'b0;
`endif

endmodule

`default_nettype wire
